// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini SRC control sequencer: instruction
// opcodes, ALU operation codes, the sequencer state encoding and the
// instruction classes produced by the opcode decoder.
package cpu_pkg;

    // Instruction opcodes as they appear in IR[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation selects driven on the opcode output
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;

    // Sequencer steps; T0..T7 are consecutive so the FSM can count through them
    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    // Instructions grouped by the shape of their T3..T7 control sequence
    typedef enum logic [3:0] {
        CLS_NOP, CLS_HALT, CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_R, CLS_ALU_UN,
        CLS_ALU_I, CLS_MULDIV, CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT,
        CLS_MFHI, CLS_MFLO
    } instr_class_t;

    // Immediate ALU instructions reuse the register-form ALU operations
    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the DataPath (slave):
// instruction/condition feedback in, register-transfer strobes out.
interface control_unit_if;

    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;
    logic        Run;

    logic PC_out, ZHigh_out, ZLow_out, HI_out, LO_out;
    logic C_out, MDR_out, in_port_out, BA_out, R_out;

    logic PC_enable, IncPC, MAR_enable, MDR_enable, IR_enable, Y_enable;
    logic Z_enable, HI_enable, LO_enable, R_in, con_in, out_port_enable;
    logic RAM_write_enable;

    logic Gra, Grb, Grc;
    logic Read;
    logic [4:0] opcode;

    modport master (
        input  IR, CON_FF, Stop,
        output Run,
        output PC_out, ZHigh_out, ZLow_out, HI_out, LO_out,
        output C_out, MDR_out, in_port_out, BA_out, R_out,
        output PC_enable, IncPC, MAR_enable, MDR_enable, IR_enable, Y_enable,
        output Z_enable, HI_enable, LO_enable, R_in, con_in, out_port_enable,
        output RAM_write_enable, Gra, Grb, Grc, Read, opcode
    );

    modport slave (
        output IR, CON_FF, Stop,
        input  Run,
        input  PC_out, ZHigh_out, ZLow_out, HI_out, LO_out,
        input  C_out, MDR_out, in_port_out, BA_out, R_out,
        input  PC_enable, IncPC, MAR_enable, MDR_enable, IR_enable, Y_enable,
        input  Z_enable, HI_enable, LO_enable, R_in, con_in, out_port_enable,
        input  RAM_write_enable, Gra, Grb, Grc, Read, opcode
    );

endinterface

// File: rtl/cu_decode.sv
// Opcode decoder: classifies IR[31:27] and reports the final step of the
// instruction. Macro CU_MULDIV_EN enables mul/div; without it they act as nop.
module cu_decode import cpu_pkg::*; (
    input  logic [4:0]   op,
    output instr_class_t cls,
    output state_t       last_step
);

    // Opcode to instruction class; anything unlisted behaves as nop
    always_comb begin
        cls = CLS_NOP;
        case (op)
            OP_LD:   cls = CLS_LD;
            OP_LDI:  cls = CLS_LDI;
            OP_ST:   cls = CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL: cls = CLS_ALU_R;
            OP_NEG, OP_NOT: cls = CLS_ALU_UN;
            OP_ADDI, OP_ANDI, OP_ORI: cls = CLS_ALU_I;
`ifdef CU_MULDIV_EN
            OP_MUL, OP_DIV: cls = CLS_MULDIV;
`else
            OP_MUL, OP_DIV: cls = CLS_NOP;
`endif
            OP_BR:   cls = CLS_BR;
            OP_JR:   cls = CLS_JR;
            OP_JAL:  cls = CLS_JAL;
            OP_IN:   cls = CLS_IN;
            OP_OUT:  cls = CLS_OUT;
            OP_MFHI: cls = CLS_MFHI;
            OP_MFLO: cls = CLS_MFLO;
            OP_NOP:  cls = CLS_NOP;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
        endcase
    end

    // Final step of each class; fetch alone ends at T2
    always_comb begin
        last_step = T2;
        case (cls)
            CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO: last_step = T3;
            CLS_JAL:                                     last_step = T4;
            CLS_LDI, CLS_ALU_R, CLS_ALU_UN, CLS_ALU_I:   last_step = T5;
            CLS_MULDIV, CLS_BR:                          last_step = T6;
            CLS_LD, CLS_ST:                              last_step = T7;
            default:                                     last_step = T2;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath. Steps through
// T0..T7 per instruction and drives register-transfer strobes from the state
// and IR. Macro CU_MULDIV_EN (in cu_decode) enables mul/div sequences.
module control_unit import cpu_pkg::*; (
    input  logic           Clock,
    input  logic           clr,
    control_unit_if.master bus
);

    state_t       state;
    instr_class_t cls;
    state_t       last_step;
    logic         stop_pending;
    logic [4:0]   op;
    logic         unused_ir_bits;

    assign op             = bus.IR[31:27];
    assign unused_ir_bits = ^bus.IR[26:0];

    cu_decode u_decode (
        .op        (op),
        .cls       (cls),
        .last_step (last_step)
    );

    // Step sequencing; a Stop request is remembered until the instruction ends.
    // The T2 exit already looks at IR so nop/halt finish after fetch.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            state        <= RESET;
            stop_pending <= 1'b0;
        end else begin
            if (bus.Stop)
                stop_pending <= 1'b1;
            case (state)
                RESET: state <= T0;
                HALT:  state <= HALT;
                default: begin
                    if (state >= T2 && state >= last_step) begin
                        if (cls == CLS_HALT || bus.Stop || stop_pending)
                            state <= HALT;
                        else
                            state <= T0;
                    end else begin
                        state <= state_t'(state + 4'd1);
                    end
                end
            endcase
        end
    end

    // Moore strobe decode: fetch steps are fixed, T3..T7 depend on the class
    always_comb begin
        bus.Run              = (state != RESET) && (state != HALT);
        bus.PC_out           = 1'b0;
        bus.ZHigh_out        = 1'b0;
        bus.ZLow_out         = 1'b0;
        bus.HI_out           = 1'b0;
        bus.LO_out           = 1'b0;
        bus.C_out            = 1'b0;
        bus.MDR_out          = 1'b0;
        bus.in_port_out      = 1'b0;
        bus.BA_out           = 1'b0;
        bus.R_out            = 1'b0;
        bus.PC_enable        = 1'b0;
        bus.IncPC            = 1'b0;
        bus.MAR_enable       = 1'b0;
        bus.MDR_enable       = 1'b0;
        bus.IR_enable        = 1'b0;
        bus.Y_enable         = 1'b0;
        bus.Z_enable         = 1'b0;
        bus.HI_enable        = 1'b0;
        bus.LO_enable        = 1'b0;
        bus.R_in             = 1'b0;
        bus.con_in           = 1'b0;
        bus.out_port_enable  = 1'b0;
        bus.RAM_write_enable = 1'b0;
        bus.Gra              = 1'b0;
        bus.Grb              = 1'b0;
        bus.Grc              = 1'b0;
        bus.Read             = 1'b0;
        bus.opcode           = ALU_NONE;
        case (state)
            T0: begin
                bus.PC_out = 1'b1; bus.MAR_enable = 1'b1;
                bus.IncPC  = 1'b1; bus.PC_enable  = 1'b1;
            end
            T1: begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; end
            T2: begin bus.MDR_out = 1'b1; bus.IR_enable = 1'b1; end
            T3: case (cls)
                CLS_LD, CLS_LDI, CLS_ST: begin
                    bus.Grb = 1'b1; bus.BA_out = 1'b1; bus.Y_enable = 1'b1;
                end
                CLS_ALU_R, CLS_ALU_UN, CLS_ALU_I: begin
                    bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1;
                end
                CLS_MULDIV: begin
                    bus.Gra = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1;
                end
                CLS_BR:  begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.con_in = 1'b1; end
                CLS_JR:  begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_enable = 1'b1; end
                CLS_JAL: begin bus.PC_out = 1'b1; bus.R_in = 1'b1; end
                CLS_IN:  begin bus.in_port_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                CLS_OUT: begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.out_port_enable = 1'b1; end
                CLS_MFHI: begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                CLS_MFLO: begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                default: ;
            endcase
            T4: case (cls)
                CLS_LD, CLS_LDI, CLS_ST: begin
                    bus.C_out = 1'b1; bus.opcode = ALU_ADD; bus.Z_enable = 1'b1;
                end
                CLS_ALU_R: begin
                    bus.Grc = 1'b1; bus.R_out = 1'b1; bus.opcode = op; bus.Z_enable = 1'b1;
                end
                CLS_ALU_UN: begin bus.R_out = 1'b1; bus.opcode = op; bus.Z_enable = 1'b1; end
                CLS_ALU_I: begin
                    bus.C_out = 1'b1; bus.opcode = imm_alu_op(op); bus.Z_enable = 1'b1;
                end
                CLS_MULDIV: begin
                    bus.Grb = 1'b1; bus.R_out = 1'b1; bus.opcode = op; bus.Z_enable = 1'b1;
                end
                CLS_BR:  begin bus.PC_out = 1'b1; bus.Y_enable = 1'b1; end
                CLS_JAL: begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_enable = 1'b1; end
                default: ;
            endcase
            T5: case (cls)
                CLS_LD, CLS_ST: begin bus.ZLow_out = 1'b1; bus.MAR_enable = 1'b1; end
                CLS_LDI, CLS_ALU_R, CLS_ALU_UN, CLS_ALU_I: begin
                    bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1;
                end
                CLS_MULDIV: begin bus.ZLow_out = 1'b1; bus.LO_enable = 1'b1; end
                CLS_BR: begin
                    bus.C_out = 1'b1; bus.opcode = ALU_ADD; bus.Z_enable = 1'b1;
                end
                default: ;
            endcase
            T6: case (cls)
                CLS_LD:     begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; end
                CLS_ST:     begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.MDR_enable = 1'b1; end
                CLS_MULDIV: begin bus.ZHigh_out = 1'b1; bus.HI_enable = 1'b1; end
                CLS_BR: begin
                    bus.ZLow_out  = bus.CON_FF;
                    bus.PC_enable = bus.CON_FF;
                end
                default: ;
            endcase
            T7: case (cls)
                CLS_LD: begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                CLS_ST: begin bus.MDR_out = 1'b1; bus.RAM_write_enable = 1'b1; end
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instructions step by step and
// compares Run, opcode and every strobe against hand-derived values.
module tb_control_unit;
    import cpu_pkg::*;

    logic Clock;
    logic clr;
    int   assertions;
    int   failures;

    control_unit_if bus ();

    control_unit dut (
        .Clock (Clock),
        .clr   (clr),
        .bus   (bus)
    );

    // Strobe masks, one bit per output
    localparam logic [26:0] M_PC_OUT    = 27'd1 << 0;
    localparam logic [26:0] M_ZHIGH_OUT = 27'd1 << 1;
    localparam logic [26:0] M_ZLOW_OUT  = 27'd1 << 2;
    localparam logic [26:0] M_HI_OUT    = 27'd1 << 3;
    localparam logic [26:0] M_LO_OUT    = 27'd1 << 4;
    localparam logic [26:0] M_C_OUT     = 27'd1 << 5;
    localparam logic [26:0] M_MDR_OUT   = 27'd1 << 6;
    localparam logic [26:0] M_INP_OUT   = 27'd1 << 7;
    localparam logic [26:0] M_BA_OUT    = 27'd1 << 8;
    localparam logic [26:0] M_R_OUT     = 27'd1 << 9;
    localparam logic [26:0] M_PC_EN     = 27'd1 << 10;
    localparam logic [26:0] M_INC_PC    = 27'd1 << 11;
    localparam logic [26:0] M_MAR_EN    = 27'd1 << 12;
    localparam logic [26:0] M_MDR_EN    = 27'd1 << 13;
    localparam logic [26:0] M_IR_EN     = 27'd1 << 14;
    localparam logic [26:0] M_Y_EN      = 27'd1 << 15;
    localparam logic [26:0] M_Z_EN      = 27'd1 << 16;
    localparam logic [26:0] M_HI_EN     = 27'd1 << 17;
    localparam logic [26:0] M_LO_EN     = 27'd1 << 18;
    localparam logic [26:0] M_R_IN      = 27'd1 << 19;
    localparam logic [26:0] M_CON_IN    = 27'd1 << 20;
    localparam logic [26:0] M_OUTP_EN   = 27'd1 << 21;
    localparam logic [26:0] M_RAM_WE    = 27'd1 << 22;
    localparam logic [26:0] M_GRA       = 27'd1 << 23;
    localparam logic [26:0] M_GRB       = 27'd1 << 24;
    localparam logic [26:0] M_GRC       = 27'd1 << 25;
    localparam logic [26:0] M_READ      = 27'd1 << 26;

    localparam logic [26:0] F0 = M_PC_OUT | M_MAR_EN | M_INC_PC | M_PC_EN;
    localparam logic [26:0] F1 = M_READ | M_MDR_EN;
    localparam logic [26:0] F2 = M_MDR_OUT | M_IR_EN;
    localparam logic [26:0] NONE = 27'd0;

    logic [26:0] strobes;
    assign strobes = {bus.Read, bus.Grc, bus.Grb, bus.Gra, bus.RAM_write_enable,
                      bus.out_port_enable, bus.con_in, bus.R_in, bus.LO_enable,
                      bus.HI_enable, bus.Z_enable, bus.Y_enable, bus.IR_enable,
                      bus.MDR_enable, bus.MAR_enable, bus.IncPC, bus.PC_enable,
                      bus.R_out, bus.BA_out, bus.in_port_out, bus.MDR_out,
                      bus.C_out, bus.LO_out, bus.HI_out, bus.ZLow_out,
                      bus.ZHigh_out, bus.PC_out};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic apply_stimulus(input logic [31:0] ir, input logic con, input logic stop);
        bus.IR     = ir;
        bus.CON_FF = con;
        bus.Stop   = stop;
    endtask

    task automatic check_output(input string tag, input logic exp_run,
                                input logic [4:0] exp_op, input logic [26:0] exp_strobes);
        logic [32:0] obs;
        logic [32:0] exp;
        obs = {bus.Run, bus.opcode, strobes};
        exp = {exp_run, exp_op, exp_strobes};
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got run=%0b op=%05b strobes=%07h, expected run=%0b op=%05b strobes=%07h",
                   tag, obs[32], obs[31:27], obs[26:0], exp[32], exp[31:27], exp[26:0]);
        end
    endtask

    task automatic step(input string tag, input logic exp_run,
                        input logic [4:0] exp_op, input logic [26:0] exp_strobes);
        @(posedge Clock);
        #1;
        check_output(tag, exp_run, exp_op, exp_strobes);
    endtask

    task automatic fetch_rest();
        step("T1 fetch", 1'b1, ALU_NONE, F1);
        step("T2 fetch", 1'b1, ALU_NONE, F2);
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        clr        = 1'b0;
        apply_stimulus(32'd0, 1'b0, 1'b0);
        #1;
        check_output("reset held", 1'b0, ALU_NONE, NONE);
        @(negedge Clock);
        clr = 1'b1;
        check_output("reset released pre-edge", 1'b0, ALU_NONE, NONE);

        // ldi R2,0x65
        apply_stimulus({OP_LDI, 4'd2, 4'd0, 19'h65}, 1'b0, 1'b0);
        step("ldi T0", 1'b1, ALU_NONE, F0);
        fetch_rest();
        step("ldi T3", 1'b1, ALU_NONE, M_GRB | M_BA_OUT | M_Y_EN);
        step("ldi T4", 1'b1, ALU_ADD, M_C_OUT | M_Z_EN);
        step("ldi T5", 1'b1, ALU_NONE, M_ZLOW_OUT | M_GRA | M_R_IN);
        step("ldi next T0", 1'b1, ALU_NONE, F0);

        // st 0x1F(R1),R5
        apply_stimulus({OP_ST, 4'd5, 4'd1, 19'h1F}, 1'b0, 1'b0);
        fetch_rest();
        step("st T3", 1'b1, ALU_NONE, M_GRB | M_BA_OUT | M_Y_EN);
        step("st T4", 1'b1, ALU_ADD, M_C_OUT | M_Z_EN);
        step("st T5", 1'b1, ALU_NONE, M_ZLOW_OUT | M_MAR_EN);
        step("st T6", 1'b1, ALU_NONE, M_GRA | M_R_OUT | M_MDR_EN);
        step("st T7", 1'b1, ALU_NONE, M_MDR_OUT | M_RAM_WE);
        step("st next T0", 1'b1, ALU_NONE, F0);

        // brzr R2 with CON_FF=0
        apply_stimulus({OP_BR, 4'd2, 4'd0, 19'h10}, 1'b0, 1'b0);
        fetch_rest();
        step("br0 T3", 1'b1, ALU_NONE, M_GRA | M_R_OUT | M_CON_IN);
        step("br0 T4", 1'b1, ALU_NONE, M_PC_OUT | M_Y_EN);
        step("br0 T5", 1'b1, ALU_ADD, M_C_OUT | M_Z_EN);
        step("br0 T6", 1'b1, ALU_NONE, NONE);
        step("br0 next T0", 1'b1, ALU_NONE, F0);

        // brzr R2 with CON_FF=1, then dropped inside T6
        fetch_rest();
        step("br1 T3", 1'b1, ALU_NONE, M_GRA | M_R_OUT | M_CON_IN);
        step("br1 T4", 1'b1, ALU_NONE, M_PC_OUT | M_Y_EN);
        step("br1 T5", 1'b1, ALU_ADD, M_C_OUT | M_Z_EN);
        bus.CON_FF = 1'b1;
        step("br1 T6", 1'b1, ALU_NONE, M_ZLOW_OUT | M_PC_EN);
        bus.CON_FF = 1'b0;
        #1;
        check_output("br T6 con dropped", 1'b1, ALU_NONE, NONE);
        step("br1 next T0", 1'b1, ALU_NONE, F0);

        // neg R1,R2 (no Grc in T4)
        apply_stimulus({OP_NEG, 4'd1, 4'd2, 19'h0}, 1'b0, 1'b0);
        fetch_rest();
        step("neg T3", 1'b1, ALU_NONE, M_GRB | M_R_OUT | M_Y_EN);
        step("neg T4", 1'b1, OP_NEG, M_R_OUT | M_Z_EN);
        step("neg T5", 1'b1, ALU_NONE, M_ZLOW_OUT | M_GRA | M_R_IN);
        step("neg next T0", 1'b1, ALU_NONE, F0);

        // andi R3,R4,0x7 maps to ALU and
        apply_stimulus({OP_ANDI, 4'd3, 4'd4, 19'h7}, 1'b0, 1'b0);
        fetch_rest();
        step("andi T3", 1'b1, ALU_NONE, M_GRB | M_R_OUT | M_Y_EN);
        step("andi T4", 1'b1, ALU_AND, M_C_OUT | M_Z_EN);
        step("andi T5", 1'b1, ALU_NONE, M_ZLOW_OUT | M_GRA | M_R_IN);
        step("andi next T0", 1'b1, ALU_NONE, F0);

        // jr R6 then jal R7
        apply_stimulus({OP_JR, 4'd6, 4'd0, 19'h0}, 1'b0, 1'b0);
        fetch_rest();
        step("jr T3", 1'b1, ALU_NONE, M_GRA | M_R_OUT | M_PC_EN);
        step("jr next T0", 1'b1, ALU_NONE, F0);
        apply_stimulus({OP_JAL, 4'd7, 4'd0, 19'h0}, 1'b0, 1'b0);
        fetch_rest();
        step("jal T3", 1'b1, ALU_NONE, M_PC_OUT | M_R_IN);
        step("jal T4", 1'b1, ALU_NONE, M_GRA | M_R_OUT | M_PC_EN);
        step("jal next T0", 1'b1, ALU_NONE, F0);

        // mfhi R8 and undefined opcode 11111
        apply_stimulus({OP_MFHI, 4'd8, 4'd0, 19'h0}, 1'b0, 1'b0);
        fetch_rest();
        step("mfhi T3", 1'b1, ALU_NONE, M_HI_OUT | M_GRA | M_R_IN);
        step("mfhi next T0", 1'b1, ALU_NONE, F0);
        apply_stimulus({5'b11111, 27'h0}, 1'b0, 1'b0);
        fetch_rest();
        step("undef next T0", 1'b1, ALU_NONE, F0);

        // mul R3,R4
        apply_stimulus({OP_MUL, 4'd3, 4'd4, 19'h0}, 1'b0, 1'b0);
        fetch_rest();
`ifdef CU_MULDIV_EN
        step("mul T3", 1'b1, ALU_NONE, M_GRA | M_R_OUT | M_Y_EN);
        step("mul T4", 1'b1, OP_MUL, M_GRB | M_R_OUT | M_Z_EN);
        step("mul T5", 1'b1, ALU_NONE, M_ZLOW_OUT | M_LO_EN);
        step("mul T6", 1'b1, ALU_NONE, M_ZHIGH_OUT | M_HI_EN);
`endif
        step("mul next T0", 1'b1, ALU_NONE, F0);

        // ld interrupted by clr during T4
        apply_stimulus({OP_LD, 4'd1, 4'd2, 19'h4}, 1'b0, 1'b0);
        fetch_rest();
        step("ld T3", 1'b1, ALU_NONE, M_GRB | M_BA_OUT | M_Y_EN);
        step("ld T4", 1'b1, ALU_ADD, M_C_OUT | M_Z_EN);
        clr = 1'b0;
        #1;
        check_output("ld clr mid", 1'b0, ALU_NONE, NONE);
        @(negedge Clock);
        clr = 1'b1;
        step("ld clr release T0", 1'b1, ALU_NONE, F0);

        // add R1,R2,R3 with Stop raised during T4
        apply_stimulus({OP_ADD, 4'd1, 4'd2, 4'd3, 15'h0}, 1'b0, 1'b0);
        fetch_rest();
        step("add T3", 1'b1, ALU_NONE, M_GRB | M_R_OUT | M_Y_EN);
        step("add T4", 1'b1, ALU_ADD, M_GRC | M_R_OUT | M_Z_EN);
        bus.Stop = 1'b1;
        step("add stop T5", 1'b1, ALU_NONE, M_ZLOW_OUT | M_GRA | M_R_IN);
        bus.Stop = 1'b0;
        step("stop halt", 1'b0, ALU_NONE, NONE);
        step("stop halt hold", 1'b0, ALU_NONE, NONE);
        clr = 1'b0;
        #1;
        check_output("halt clr", 1'b0, ALU_NONE, NONE);
        @(negedge Clock);
        clr = 1'b1;
        step("after halt T0", 1'b1, ALU_NONE, F0);

        // halt instruction, then HALT held for 20 cycles
        apply_stimulus({OP_HALT, 27'h0}, 1'b0, 1'b0);
        fetch_rest();
        for (int i = 0; i < 20; i++)
            step("halt hold", 1'b0, ALU_NONE, NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
